ripple_add_sequencer: RTL and testbench
=======================================

# ripple_add_sequencer

Multi-cycle controller that computes wide additions by time-sharing a single 4-bit ripple-carry adder slice. Operands of 4·NIBBLES bits are accepted over a valid/ready handshake and added one nibble per clock, least-significant first. The inter-slice carry is kept in a register. The block sits between an operand producer and a result consumer wherever a full-width adder is too costly.

## Interface
- NIBBLES, default 4, number of 4-bit slices; operand width W = 4·NIBBLES; legal range 1–16
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- a  in  W  operand A
- b  in  W  operand B
- cin  in  1  carry-in to slice 0
- sub  in  1  subtract request; present only with ADDSEQ_SUB_EN
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  W  result
- cout  out  1  carry out of the top slice

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid is high, the block captures a, b and cin (and sub) into registers, clears sum, sets slice index idx=0 and goes to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle it adds slice idx: {c, s} = a[4idx+:4] + b[4idx+:4] + carry.
  - It writes s into sum[4idx+:4], sets carry←c and idx←idx+1.
  - After slice NIBBLES-1 it sets cout←c and goes to DONE.
- DONE:
  - out_valid=1.
  - sum and cout stay stable until out_ready is high, then the FSM returns to IDLE.
  - in_valid is ignored while in DONE.
- Arithmetic is modulo 2^W. cout is the true carry out of bit W-1.
- idx is $clog2(NIBBLES) bits wide (minimum 1) and never wraps during an operation.
- Operand registers are the only source for the slice. Input changes after acceptance have no effect.
- Reset (any state, including mid-RUN) aborts the operation:
  - state=IDLE, idx=0, carry=0
  - sum=0, cout=0, out_valid=0, in_ready=1 from the cycle after the reset edge

## Timing
- Acceptance happens at edge T0, when in_valid && in_ready.
- Slices 0..NIBBLES-1 are computed at edges T1..T_NIBBLES.
- out_valid is high from the cycle after edge T_NIBBLES. Latency from acceptance to result is NIBBLES cycles.
- If out_ready is high at edge Td, the FSM is in IDLE after Td and in_ready is high. The next operation can be accepted at Td+1.
- Minimum period per operation is NIBBLES+2 cycles.
- Outputs are registered. There is no combinational path from inputs to outputs except in_ready and out_valid, which depend on the state register only.

## Configuration
- With ADDSEQ_SUB_EN defined:
  - The sub port exists and is captured at acceptance.
  - When sub=1, each slice uses ~b[4idx+:4], the initial carry is forced to 1 and cin is ignored. The result is A−B mod 2^W.
  - cout=1 means no borrow.
- Without ADDSEQ_SUB_EN, the sub port and the b-inversion logic are absent and the block adds only.

## Structure
- Package adder_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - constant SLICE_W=4
- One sub-module is natural: the team's existing 4-bit adder ripple_adder4 (a, b, cin → sum, cout), instantiated once as the shared slice.
- The block itself contains the FSM, the operand, index and carry registers, and the result register.

## Test plan
All scenarios use NIBBLES=4.
- Accept a=0x0003, b=0x000C, cin=0 → after 4 cycles out_valid=1, sum=0x000F, cout=0.
- Accept a=0x0001, b=0xFFFF, cin=1 → sum=0x0001, cout=1; the carry ripples through all four slices.
- Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands → sum and cout stay stable, in_ready=0, and the new operands are not taken. Raising out_ready → IDLE, then the new operands are accepted the following cycle.
- Assert rst during RUN at idx=2 → the next cycle shows state IDLE, out_valid=0, sum=0, cout=0, in_ready=1. The next accepted operation then produces a correct result.
- With ADDSEQ_SUB_EN, apply a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, cout=0. Then apply a=0x0007, b=0x0005, sub=1 → sum=0x0002, cout=1.
- Back-to-back: hold in_valid and out_ready high for 3 operations → one result every 6 cycles, each matching a+b+cin.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the ripple-add sequencer.
package adder_seq_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } addseq_state_e;

endpackage

// File: rtl/ripple_adder4.sv
// 4-bit ripple-carry adder slice, shared by the sequencer across all nibbles.
module ripple_adder4
    import adder_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[SLICE_W];
    end

endmodule

// File: rtl/ripple_add_sequencer.sv
// Wide adder that time-shares one 4-bit ripple slice, one nibble per clock, LSB first.
// Define ADDSEQ_SUB_EN to add the sub port and A-B support.
module ripple_add_sequencer
    import adder_seq_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SLICE_W*NIBBLES-1:0] a,
    input  logic [SLICE_W*NIBBLES-1:0] b,
    input  logic                   cin,
`ifdef ADDSEQ_SUB_EN
    input  logic                   sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SLICE_W*NIBBLES-1:0] sum,
    output logic                   cout
);

    localparam int unsigned W    = SLICE_W * NIBBLES;
    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    addseq_state_e   state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
`ifdef ADDSEQ_SUB_EN
    logic            sub_q, sub_d;
`endif

    logic [SLICE_W-1:0] a_slice, b_slice, b_op, s_slice;
    logic               c_slice;

    // Slice operands come only from the captured registers.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IdxW'(i)) begin
                a_slice = a_q[i*SLICE_W +: SLICE_W];
                b_slice = b_q[i*SLICE_W +: SLICE_W];
            end
        end
`ifdef ADDSEQ_SUB_EN
        b_op = b_slice ^ {SLICE_W{sub_q}};
`else
        b_op = b_slice;
`endif
    end

    ripple_adder4 u_slice (
        .a    (a_slice),
        .b    (b_op),
        .cin  (carry_q),
        .sum  (s_slice),
        .cout (c_slice)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef ADDSEQ_SUB_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    idx_d   = '0;
`ifdef ADDSEQ_SUB_EN
                    sub_d   = sub;
                    // Two's-complement subtract: invert b and inject +1 as carry-in.
                    carry_d = sub ? 1'b1 : cin;
`else
                    carry_d = cin;
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IdxW'(i)) begin
                        sum_d[i*SLICE_W +: SLICE_W] = s_slice;
                    end
                end
                carry_d = c_slice;
                if (idx_q == LastIdx) begin
                    cout_d  = c_slice;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef ADDSEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef ADDSEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Randomized self-checking bench for ripple_add_sequencer (NIBBLES=4).
module tb_ripple_add_sequencer;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ripple_add_sequencer #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDSEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain W+1-bit arithmetic; subtract is a + ~b + 1.
    function automatic logic [W:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c, input logic s);
        logic [W-1:0] yy;
        yy = s ? ~y : y;
        return {1'b0, x} + {1'b0, yy} + ((s ? 1'b1 : c) ? 17'd1 : 17'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                          input logic is_);
        int n;
        logic [W:0] e;
        e = ref_model(ia, ib, ic, is_);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check_eq("ready_before_accept", 32'(in_ready), 32'd1);
        a = ia; b = ib; cin = ic; sub = is_; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble();
        check_eq("ready_drops", 32'(in_ready), 32'd0);
        wait_valid(n);
        check_eq("latency", 32'(n), 32'(N));
        check_eq("sum", 32'(sum), 32'(e[W-1:0]));
        check_eq("cout", 32'(cout), 32'(e[W]));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("idle_after_ack", 32'(in_ready), 32'd1);
        check_eq("valid_after_ack", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        int t_prev;
        logic [W:0] e;
        logic [W:0] e2;
        logic [W-1:0] oa [3];
        logic [W-1:0] ob [3];
        logic         oc [3];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_cout", 32'(cout), 32'd0);

        run_op(16'h0003, 16'h000C, 1'b0, 1'b0);
        run_op(16'h0001, 16'hFFFF, 1'b1, 1'b0);

        // Stall in DONE with new operands offered; they must wait.
        e  = ref_model(16'h1234, 16'h4321, 1'b1, 1'b0);
        e2 = ref_model(16'hBEEF, 16'h1111, 1'b0, 1'b0);
        a = 16'h1234; b = 16'h4321; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'hBEEF; b = 16'h1111; cin = 1'b0;
        wait_valid(n);
        check_eq("hold_latency", 32'(n), 32'(N));
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("hold_sum", 32'(sum), 32'(e[W-1:0]));
            check_eq("hold_cout", 32'(cout), 32'(e[W]));
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
            check_eq("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("hold_release_idle", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_eq("hold_next_taken", 32'(in_ready), 32'd0);
        scramble();
        wait_valid(n);
        check_eq("hold_next_latency", 32'(n), 32'(N));
        check_eq("hold_next_sum", 32'(sum), 32'(e2[W-1:0]));
        check_eq("hold_next_cout", 32'(cout), 32'(e2[W]));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset mid-run at idx=2.
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_sum", 32'(sum), 32'd0);
        check_eq("midrst_cout", 32'(cout), 32'd0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);

`ifdef ADDSEQ_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1);
`endif

        // Back-to-back: in_valid and out_ready held high.
        for (int k = 0; k < 3; k++) begin
            oa[k] = W'($urandom);
            ob[k] = W'($urandom);
            oc[k] = 1'($urandom);
        end
        out_ready = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            a = oa[k]; b = ob[k]; cin = oc[k]; sub = 1'b0; in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            tick();
            if (k > 0) check_eq("b2b_period", 32'(cyc - t_prev), 32'(N + 2));
            t_prev = cyc;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            e = ref_model(oa[k], ob[k], oc[k], 1'b0);
            wait_valid(n);
            check_eq("b2b_latency", 32'(n), 32'(N));
            check_eq("b2b_sum", 32'(sum), 32'(e[W-1:0]));
            check_eq("b2b_cout", 32'(cout), 32'(e[W]));
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;

        for (int k = 0; k < 20; k++) begin
`ifdef ADDSEQ_SUB_EN
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`else
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
